// File: rtl/sm_cpu_mc_if.sv
// sm_cpu_mc_if -- instruction and data memory bus of the multi-cycle schoolMIPS core.
//
// Both memories use a req/ack handshake. The requester raises req and holds the
// address (and, for stores, the data) stable until it sees ack high at a rising
// clock edge. Memories may insert any number of wait states.
//
// Signals (direction given from the CPU/master side):
//   imAddr  out  ADDR_WIDTH  instruction word address
//   imReq   out  1           instruction fetch request
//   imAck   in   1           fetch complete; imData valid in this cycle
//   imData  in   32          instruction word
//   dmAddr  out  ADDR_WIDTH  data word address
//   dmReq   out  1           data access request
//   dmWe    out  1           1 = store, 0 = load
//   dmWData out  32          store data
//   dmAck   in   1           access complete; dmRData valid in this cycle for loads
//   dmRData in   32          load data
interface sm_cpu_mc_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] imAddr;
   logic                  imReq;
   logic                  imAck;
   logic [31:0]           imData;
   logic [ADDR_WIDTH-1:0] dmAddr;
   logic                  dmReq;
   logic                  dmWe;
   logic [31:0]           dmWData;
   logic                  dmAck;
   logic [31:0]           dmRData;

   modport master (
      output imAddr, imReq,
      input  imAck, imData,
      output dmAddr, dmReq, dmWe, dmWData,
      input  dmAck, dmRData
   );

   modport slave (
      input  imAddr, imReq,
      output imAck, imData,
      input  dmAddr, dmReq, dmWe, dmWData,
      output dmAck, dmRData
   );
endinterface

// File: rtl/sm_cpu_mc.sv
// sm_cpu_mc -- multi-cycle schoolMIPS core with handshaked instruction/data memories.
//
// Each instruction goes through FETCH -> EXEC -> (MEM) -> FETCH. With zero-wait
// memories, ALU and branch instructions take 2 cycles and lw/sw take 3.
//
// Parameters:
//   ADDR_WIDTH  width of pc and the memory word addresses (2..32)
//   RESET_PC    pc loaded on reset, truncated to ADDR_WIDTH
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   rst_n    synchronous reset, active low
//   regAddr  debug register select
//   regData  debug read data: pc (zero-extended) when regAddr==0, else GPR[regAddr]
//   retire   one-cycle pulse when an instruction completes
//   bus      instruction/data memory handshake bus (sm_cpu_mc_if.master)
//
// Configuration macro SM_CPU_MC_REGIMM_EN: when defined, opcode 000001 is decoded
// as bltz (rt=0) / bgez (rt=1). When undefined, that opcode executes as a NOP.
module sm_cpu_mc #(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic        retire,
   sm_cpu_mc_if.master bus
);

   // opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
`ifdef SM_CPU_MC_REGIMM_EN
   localparam logic [5:0] OP_REGIMM = 6'h01;
`endif
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   // R-type funct codes
   localparam logic [5:0] FN_SRL    = 6'h02;
   localparam logic [5:0] FN_SRLV   = 6'h06;
   localparam logic [5:0] FN_ADDU   = 6'h21;
   localparam logic [5:0] FN_SUBU   = 6'h23;
   localparam logic [5:0] FN_AND    = 6'h24;
   localparam logic [5:0] FN_OR     = 6'h25;
   localparam logic [5:0] FN_NOR    = 6'h27;
   localparam logic [5:0] FN_SLTU   = 6'h2b;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0] pc, pc_nx;
   logic [31:0]           ir;

   // data access latched in EXEC so the bus stays stable for the whole MEM phase
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic                  dm_we;
   logic [31:0]           dm_wdata;

   // register file; entry 0 is never written and never read as an operand
   logic [31:0] gpr [32];

   // instruction fields
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] sign_imm;

   assign opcode   = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign shamt    = ir[10:6];
   assign funct    = ir[5:0];
   assign imm      = ir[15:0];
   assign sign_imm = {{16{imm[15]}}, imm};

   // operand read with $0 hard-wired to zero
   logic [31:0] rs_val, rt_val;
   assign rs_val = (rs == 5'd0) ? 32'd0 : gpr[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : gpr[rt];

   // pc arithmetic is done at 32 bits and truncated, which gives wrap modulo 2^ADDR_WIDTH
   logic [ADDR_WIDTH-1:0] pc_inc, br_target;
   logic [31:0]           br_sum, mem_sum;

   assign pc_inc    = pc + ADDR_WIDTH'(1);
   assign br_sum    = 32'(pc) + 32'd1 + sign_imm;
   assign br_target = br_sum[ADDR_WIDTH-1:0];
   assign mem_sum   = rs_val + sign_imm;

   // ------------------------------------------------------------------
   // Decode / execute. Anything not recognised falls out with all
   // enables low, which is the NOP behaviour.
   // ------------------------------------------------------------------
   logic        alu_wr;
   logic [4:0]  alu_dst;
   logic [31:0] alu_res;
   logic        br_taken;
   logic        is_mem;
   logic        mem_we;

   always_comb begin
      alu_wr   = 1'b0;
      alu_dst  = rd;
      alu_res  = 32'd0;
      br_taken = 1'b0;
      is_mem   = 1'b0;
      mem_we   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            alu_dst = rd;
            case (funct)
               FN_ADDU: begin alu_wr = 1'b1; alu_res = rs_val + rt_val;              end
               FN_SUBU: begin alu_wr = 1'b1; alu_res = rs_val - rt_val;              end
               FN_AND:  begin alu_wr = 1'b1; alu_res = rs_val & rt_val;              end
               FN_OR:   begin alu_wr = 1'b1; alu_res = rs_val | rt_val;              end
               FN_NOR:  begin alu_wr = 1'b1; alu_res = ~(rs_val | rt_val);           end
               FN_SLTU: begin alu_wr = 1'b1; alu_res = {31'd0, rs_val < rt_val};     end
               FN_SRL:  begin alu_wr = 1'b1; alu_res = rt_val >> shamt;              end
               FN_SRLV: begin alu_wr = 1'b1; alu_res = rt_val >> rs_val[4:0];        end
               default: ;
            endcase
         end
         OP_ADDIU: begin
            alu_wr  = 1'b1;
            alu_dst = rt;
            alu_res = rs_val + sign_imm;
         end
         OP_LUI: begin
            alu_wr  = 1'b1;
            alu_dst = rt;
            alu_res = {imm, 16'h0000};
         end
         OP_BEQ: br_taken = (rs_val == rt_val);
         OP_BNE: br_taken = (rs_val != rt_val);
         OP_LW:  is_mem   = 1'b1;
         OP_SW: begin
            is_mem = 1'b1;
            mem_we = 1'b1;
         end
`ifdef SM_CPU_MC_REGIMM_EN
         // rt selects the condition; other rt values stay a NOP
         OP_REGIMM: begin
            case (rt)
               5'd0:    br_taken =  rs_val[31];   // bltz
               5'd1:    br_taken = ~rs_val[31];   // bgez
               default: ;
            endcase
         end
`endif
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: next state, pc update, register write and bus requests
   // ------------------------------------------------------------------
   logic        ir_ld, dm_ld;
   logic        gpr_we;
   logic [4:0]  gpr_wa;
   logic [31:0] gpr_wd;
   logic        retire_c, im_req_c, dm_req_c;

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      ir_ld    = 1'b0;
      dm_ld    = 1'b0;
      gpr_we   = 1'b0;
      gpr_wa   = alu_dst;
      gpr_wd   = alu_res;
      retire_c = 1'b0;
      im_req_c = 1'b0;
      dm_req_c = 1'b0;
      case (state)
         S_FETCH: begin
            im_req_c = 1'b1;
            if (bus.imAck) begin
               ir_ld    = 1'b1;
               state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_mem) begin
               dm_ld    = 1'b1;
               state_nx = S_MEM;
            end else begin
               gpr_we   = alu_wr;
               pc_nx    = br_taken ? br_target : pc_inc;
               retire_c = 1'b1;
               state_nx = S_FETCH;
            end
         end
         S_MEM: begin
            dm_req_c = 1'b1;
            if (bus.dmAck) begin
               // ir still holds the lw/sw, so rt is the load destination
               gpr_we   = ~dm_we;
               gpr_wa   = rt;
               gpr_wd   = bus.dmRData;
               pc_nx    = pc_inc;
               retire_c = 1'b1;
               state_nx = S_FETCH;
            end
         end
         default: state_nx = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
         pc    <= RESET_PC[ADDR_WIDTH-1:0];
         ir    <= 32'd0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (ir_ld)
            ir <= bus.imData;
      end
   end

   // data access registers need no reset: they are always loaded in EXEC before MEM uses them
   always_ff @(posedge clk) begin
      if (dm_ld) begin
         dm_addr  <= mem_sum[ADDR_WIDTH-1:0];
         dm_we    <= mem_we;
         dm_wdata <= rt_val;
      end
   end

   // GPRs are not reset; writes to $0 are dropped
   always_ff @(posedge clk) begin
      if (rst_n && gpr_we && (gpr_wa != 5'd0))
         gpr[gpr_wa] <= gpr_wd;
   end

   // ------------------------------------------------------------------
   // Outputs. Requests and retire are forced low while reset is asserted,
   // so an access in progress is dropped at once.
   // ------------------------------------------------------------------
   assign bus.imAddr  = pc;
   assign bus.imReq   = rst_n & im_req_c;
   assign bus.dmAddr  = dm_addr;
   assign bus.dmReq   = rst_n & dm_req_c;
   assign bus.dmWe    = rst_n & dm_req_c & dm_we;
   assign bus.dmWData = dm_wdata;
   assign retire      = rst_n & retire_c;

   // debug port reads the array directly, so a same-cycle write shows the old value
   assign regData = (regAddr == 5'd0) ? 32'(pc) : gpr[regAddr];

endmodule

// File: tb/tb_sm_cpu_mc.sv
// tb_sm_cpu_mc -- self-checking bench for sm_cpu_mc.
// The bench plays both memories: it serves each instruction from a directed or
// random stream, and keeps a small architectural model (registers, pc, data
// memory) that says what every instruction should do.
module tb_sm_cpu_mc;
   localparam int          AW   = 4;
   localparam logic [31:0] RPC  = 32'd8;
   localparam int unsigned MASK = (1 << AW) - 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  regAddr = 5'd0;
   logic [31:0] regData;
   logic        retire;

   sm_cpu_mc_if #(.ADDR_WIDTH(AW)) bus ();

   sm_cpu_mc #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .regAddr (regAddr),
      .regData (regData),
      .retire  (retire),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   // architectural model state
   logic [31:0] R [32];
   int unsigned pcm;
   logic [31:0] dmem [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // What one instruction does to the architectural state.
   task automatic model(input logic [31:0] ins,
                        output bit wr, output logic [4:0] wa, output logic [31:0] wd,
                        output int unsigned npc, output bit mem, output bit we,
                        output int unsigned maddr, output logic [31:0] wdat);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh;
      logic [31:0] a, b, si, t;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
      a  = (rs == 0) ? 32'd0 : R[rs];
      b  = (rt == 0) ? 32'd0 : R[rt];
      si = {{16{ins[15]}}, ins[15:0]};
      t  = pcm + 32'd1 + si;
      wr = 0; wa = 0; wd = 0; mem = 0; we = 0; maddr = 0; wdat = 0;
      npc = (pcm + 1) & MASK;
      case (op)
         6'h00: begin
            wr = 1; wa = rd;
            case (fn)
               6'h21: wd = a + b;
               6'h23: wd = a - b;
               6'h24: wd = a & b;
               6'h25: wd = a | b;
               6'h27: wd = ~(a | b);
               6'h2b: wd = (a < b) ? 32'd1 : 32'd0;
               6'h02: wd = b >> sh;
               6'h06: wd = b >> a[4:0];
               default: wr = 0;
            endcase
         end
         6'h09: begin wr = 1; wa = rt; wd = a + si; end
         6'h0f: begin wr = 1; wa = rt; wd = {ins[15:0], 16'h0}; end
         6'h04: if (a == b) npc = t & MASK;
         6'h05: if (a != b) npc = t & MASK;
         6'h23: begin
            mem = 1; maddr = (a + si) & MASK;
            wr = 1; wa = rt; wd = dmem[maddr];
         end
         6'h2b: begin
            mem = 1; we = 1; maddr = (a + si) & MASK; wdat = b;
         end
`ifdef SM_CPU_MC_REGIMM_EN
         6'h01: begin
            if ((rt == 5'd0 && a[31]) || (rt == 5'd1 && !a[31])) npc = t & MASK;
         end
`endif
         default: ;
      endcase
   endtask

   // Feed one instruction with iw fetch wait states and dw data wait states.
   task automatic run_instr(input logic [31:0] ins, input int iw, input int dw);
      bit          wr, mem, we;
      logic [4:0]  wa;
      logic [31:0] wd, wdat;
      int unsigned npc, maddr;
      model(ins, wr, wa, wd, npc, mem, we, maddr, wdat);
      for (int i = 0; i < iw; i++) begin
         chk("im_req_wait", 32'(bus.imReq), 1);
         chk("im_addr_wait", 32'(bus.imAddr), pcm);
         chk("retire_wait", 32'(retire), 0);
         @(negedge clk);
      end
      chk("im_req", 32'(bus.imReq), 1);
      chk("im_addr", 32'(bus.imAddr), pcm);
      bus.imAck = 1'b1; bus.imData = ins;
      #1 chk("retire_fetch", 32'(retire), 0);
      @(negedge clk);
      bus.imAck = 1'b0; bus.imData = $urandom;
      chk("im_req_exec", 32'(bus.imReq), 0);
      if (mem) begin
         chk("retire_exec_mem", 32'(retire), 0);
         @(negedge clk);
         for (int i = 0; i <= dw; i++) begin
            chk("dm_req", 32'(bus.dmReq), 1);
            chk("dm_we", 32'(bus.dmWe), 32'(we));
            chk("dm_addr", 32'(bus.dmAddr), maddr);
            if (we) chk("dm_wdata", bus.dmWData, wdat);
            if (i < dw) begin
               chk("retire_mem_wait", 32'(retire), 0);
               @(negedge clk);
            end
         end
         bus.dmAck = 1'b1; bus.dmRData = dmem[maddr];
         #1 chk("retire_mem", 32'(retire), 1);
         @(negedge clk);
         bus.dmAck = 1'b0; bus.dmRData = $urandom;
         if (we) dmem[maddr] = wdat;
      end else begin
         chk("retire_exec", 32'(retire), 1);
         @(negedge clk);
      end
      chk("retire_after", 32'(retire), 0);
      if (wr && wa != 0) R[wa] = wd;
      pcm = npc;
      regAddr = 5'd0;
      #1 chk("pc", regData, pcm);
      if (wr && wa != 0) begin
         regAddr = wa;
         #1 chk("gpr", regData, R[wa]);
      end
      regAddr = 5'd0;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      bit          b;
      logic [31:0] ins;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      sh  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      b   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
         0:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h21};
         1:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h23};
         2:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h24};
         3:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h25};
         4:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h27};
         5:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h2b};
         6:  ins = {6'h00, 5'd0, rt, rd, sh, 6'h02};
         7:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h06};
         8:  ins = {6'h09, rs, rt, imm};
         9:  ins = {6'h0f, 5'd0, rt, imm};
         10: ins = {6'h04, rs, rt, imm};
         11: ins = {6'h05, rs, rt, imm};
         12: ins = {6'h23, rs, rt, imm};
         13: ins = {6'h2b, rs, rt, imm};
         14: ins = {6'h01, rs, (b ? 5'd1 : 5'd0), imm};
         default: ins = b ? {6'h3f, rs, rt, imm} : {6'h00, rs, rt, rd, 5'd0, 6'h3f};
      endcase
      return ins;
   endfunction

   initial begin
      int unsigned p0, exp_pc;
      for (int i = 0; i < 32; i++) R[i] = 'x;
      R[0] = 32'd0;
      for (int i = 0; i < 16; i++) dmem[i] = $urandom;
      bus.imAck = 1'b0; bus.imData = 32'd0;
      bus.dmAck = 1'b0; bus.dmRData = 32'd0;

      // reset: requests and retire low while rst_n is low, even with acks high
      @(negedge clk);
      bus.imAck = 1'b1; bus.dmAck = 1'b1;
      #1;
      chk("rst_im_req", 32'(bus.imReq), 0);
      chk("rst_dm_req", 32'(bus.dmReq), 0);
      chk("rst_dm_we", 32'(bus.dmWe), 0);
      chk("rst_retire", 32'(retire), 0);
      @(negedge clk);
      bus.imAck = 1'b0; bus.dmAck = 1'b0;
      rst_n = 1'b1;
      pcm = RPC & MASK;
      #1 chk("rst_im_addr", 32'(bus.imAddr), 32'd8);
      regAddr = 5'd0;
      #1 chk("rst_pc", regData, 32'd8);

      // addiu $1,$0,5 with zero-wait memory
      run_instr(32'h24010005, 0, 0);
      regAddr = 5'd1; #1 chk("addiu_r1", regData, 32'd5);

      // fill $2..$7 with known values
      for (int k = 2; k < 8; k++)
         run_instr({6'h09, 5'd0, 5'(k), 16'($urandom)}, 0, 0);

      // fetch with 3 wait states
      run_instr(32'h24060123, 3, 0);

      // sw $1,4($0) then lw $2,4($0) with 2-wait data memory
      run_instr(32'hAC010004, 0, 2);
      run_instr(32'h8C020004, 0, 2);
      regAddr = 5'd2; #1 chk("lw_r2", regData, 32'd5);

      // beq taken to itself, then bne not taken
      run_instr(32'h24030007, 0, 0);
      run_instr(32'h24040007, 0, 0);
      p0 = pcm;
      run_instr(32'h1064FFFF, 1, 0);
      regAddr = 5'd0; #1 chk("beq_loop", regData, p0);
      run_instr(32'h1464FFFF, 0, 0);
      regAddr = 5'd0; #1 chk("bne_fall", regData, (p0 + 1) & MASK);

      // pc wrap 15 -> 0
      for (int i = 0; i < 16 && pcm != 15; i++) run_instr(32'h0, 0, 0);
      run_instr(32'h0, 0, 0);
      regAddr = 5'd0; #1 chk("pc_wrap", regData, 32'd0);

      // reset in the middle of a store that never gets acked
      chk("mid_im_addr", 32'(bus.imAddr), pcm);
      bus.imAck = 1'b1; bus.imData = 32'hAC010004;
      @(negedge clk);
      bus.imAck = 1'b0;
      @(negedge clk);
      chk("mid_dm_req", 32'(bus.dmReq), 1);
      @(negedge clk);
      chk("mid_dm_req_hold", 32'(bus.dmReq), 1);
      rst_n = 1'b0;
      #1 chk("mid_dm_req_rst", 32'(bus.dmReq), 0);
      @(negedge clk);
      chk("mid_dm_req_after", 32'(bus.dmReq), 0);
      rst_n = 1'b1;
      pcm = RPC & MASK;
      #1 chk("mid_refetch_req", 32'(bus.imReq), 1);
      chk("mid_refetch_addr", 32'(bus.imAddr), 32'd8);
      run_instr(32'h8C070004, 0, 1);
      regAddr = 5'd7; #1 chk("gpr_kept", regData, 32'd5);

      // bltz on a negative register
      run_instr(32'h3C058000, 0, 0);
      p0 = pcm;
      run_instr(32'h04A00002, 0, 0);
`ifdef SM_CPU_MC_REGIMM_EN
      exp_pc = (p0 + 3) & MASK;
`else
      exp_pc = (p0 + 1) & MASK;
`endif
      regAddr = 5'd0; #1 chk("bltz", regData, exp_pc);

      // random instruction stream with random wait states
      for (int n = 0; n < 200; n++)
         run_instr(rnd_instr(), $urandom_range(0, 2), $urandom_range(0, 2));

      // final register sweep
      for (int k = 1; k < 8; k++) begin
         regAddr = 5'(k);
         #1 chk("final_gpr", regData, R[k]);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
